// File: rtl/vram_pkg.sv
// Shared types and defaults for the VRAM arbiter and its priority helper.
// The CLEAR state exists only when VRAM_CLEAR_EN is defined.
package vram_pkg;

  localparam int AW_DEF         = 16;
  localparam int B_DEF          = 8;
  localparam int CLR_WORDS_DEF  = 8192;
  localparam int STARVE_MAX_DEF = 4;

  localparam logic [7:0] LOCKED_RDATA = 8'hFF;

  typedef enum logic [2:0] {
`ifdef VRAM_CLEAR_EN
    ST_CLEAR,
`endif
    ST_IDLE,
    ST_WR,
    ST_RD1,
    ST_RD2,
    ST_ACK
  } vram_state_t;

endpackage

// File: rtl/vram_arb_if.sv
// CPU, PPU and VRAM-port signal bundle; slave = arbiter side, master = environment side.
interface vram_arb_if
  import vram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int B  = B_DEF
);

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [B-1:0]  cpu_wdata;
  logic          cpu_ack;
  logic [B-1:0]  cpu_rdata;

  logic          ppu_req;
  logic [AW-1:0] ppu_addr;
  logic          ppu_ack;
  logic [B-1:0]  ppu_rdata0;
  logic [B-1:0]  ppu_rdata1;

  logic          lock;
  logic          busy;

  logic [AW-1:0] vram_addr;
  logic [B-1:0]  vram_wdata;
  logic          vram_we;
  logic [B-1:0]  vram_rdata0;
  logic [B-1:0]  vram_rdata1;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ppu_req, ppu_addr, lock,
           vram_rdata0, vram_rdata1,
    output cpu_ack, cpu_rdata, ppu_ack, ppu_rdata0, ppu_rdata1,
           vram_addr, vram_wdata, vram_we, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, ppu_req, ppu_addr, lock,
           vram_rdata0, vram_rdata1,
    input  cpu_ack, cpu_rdata, ppu_ack, ppu_rdata0, ppu_rdata1,
           vram_addr, vram_wdata, vram_we, busy
  );

endinterface

// File: rtl/vram_arb_prio.sv
// Fixed PPU-priority grant decision with a CPU anti-starvation counter.
// Shared with the OAM arbiter.
module vram_arb_prio
  import vram_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic grant_en,
  input  logic cpu_req,
  input  logic ppu_req,
  output logic grant_cpu,
  output logic grant_ppu
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;
  logic          starved;

  assign starved   = (starve_cnt == SW'(STARVE_MAX));
  assign grant_ppu = grant_en && ppu_req && !(cpu_req && starved);
  assign grant_cpu = grant_en && cpu_req && !grant_ppu;

  // Counts PPU wins against a waiting CPU; a CPU win or an idle CPU resets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant_cpu || !cpu_req) begin
      starve_cnt <= '0;
    end else if (grant_ppu && !starved) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule

// File: rtl/vram_arb.sv
// VRAM port arbiter/sequencer for CPU byte access and PPU paired-byte fetch.
// Optional power-up clear sweep under VRAM_CLEAR_EN.
//
// state | meaning
// CLEAR | zeroing words 0..CLR_WORDS-1, busy=1
// IDLE  | grant decision
// WR    | CPU write strobe on the VRAM port
// RD1   | read address presented, VRAM registering
// RD2   | VRAM read data captured
// ACK   | one-cycle ack to the served requester
module vram_arb
  import vram_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int B          = B_DEF,
  parameter int CLR_WORDS  = CLR_WORDS_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input logic       clk,
  input logic       rst_n,
  vram_arb_if.slave bus
);

  vram_state_t   state;
  logic          owner_cpu;
  logic          cpu_ack, ppu_ack;
  logic [B-1:0]  cpu_rdata, ppu_rdata0, ppu_rdata1;
  logic [AW-1:0] vram_addr;
  logic [B-1:0]  vram_wdata;
  logic          vram_we;
  logic          grant_en, grant_cpu, grant_ppu;

  assign grant_en = (state == ST_IDLE);

  vram_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk       (clk),
    .rst_n     (rst_n),
    .grant_en  (grant_en),
    .cpu_req   (bus.cpu_req),
    .ppu_req   (bus.ppu_req),
    .grant_cpu (grant_cpu),
    .grant_ppu (grant_ppu)
  );

`ifdef VRAM_CLEAR_EN
  localparam int CW = $clog2(CLR_WORDS + 1);
  logic [CW-1:0] clr_cnt;
  logic          busy_q;
  assign bus.busy = busy_q;
`else
  assign bus.busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef VRAM_CLEAR_EN
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      busy_q  <= 1'b1;
`else
      state   <= ST_IDLE;
`endif
      owner_cpu  <= 1'b0;
      cpu_ack    <= 1'b0;
      ppu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      ppu_rdata0 <= '0;
      ppu_rdata1 <= '0;
      vram_addr  <= '0;
      vram_wdata <= '0;
      vram_we    <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      ppu_ack <= 1'b0;
      case (state)
`ifdef VRAM_CLEAR_EN
        ST_CLEAR: begin
          if (clr_cnt == CW'(CLR_WORDS)) begin
            vram_we <= 1'b0;
            busy_q  <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            vram_addr  <= AW'(clr_cnt);
            vram_wdata <= '0;
            vram_we    <= 1'b1;
            clr_cnt    <= clr_cnt + CW'(1);
          end
        end
`endif
        ST_IDLE: begin
          if (grant_ppu) begin
            owner_cpu <= 1'b0;
            vram_addr <= bus.ppu_addr;
            state     <= ST_RD1;
          end else if (grant_cpu) begin
            owner_cpu <= 1'b1;
            // Locked grants complete without touching the VRAM port.
            if (bus.lock) begin
              if (!bus.cpu_we) cpu_rdata <= B'(LOCKED_RDATA);
              cpu_ack <= 1'b1;
              state   <= ST_ACK;
            end else if (bus.cpu_we) begin
              vram_addr  <= bus.cpu_addr;
              vram_wdata <= bus.cpu_wdata;
              vram_we    <= 1'b1;
              state      <= ST_WR;
            end else begin
              vram_addr <= bus.cpu_addr;
              state     <= ST_RD1;
            end
          end
        end
        ST_WR: begin
          vram_we <= 1'b0;
          cpu_ack <= 1'b1;
          state   <= ST_ACK;
        end
        ST_RD1: state <= ST_RD2;
        ST_RD2: begin
          if (owner_cpu) begin
            cpu_rdata <= bus.vram_rdata0;
            cpu_ack   <= 1'b1;
          end else begin
            ppu_rdata0 <= bus.vram_rdata0;
            ppu_rdata1 <= bus.vram_rdata1;
            ppu_ack    <= 1'b1;
          end
          state <= ST_ACK;
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cpu_ack    = cpu_ack;
  assign bus.ppu_ack    = ppu_ack;
  assign bus.cpu_rdata  = cpu_rdata;
  assign bus.ppu_rdata0 = ppu_rdata0;
  assign bus.ppu_rdata1 = ppu_rdata1;
  assign bus.vram_addr  = vram_addr;
  assign bus.vram_wdata = vram_wdata;
  assign bus.vram_we    = vram_we;

endmodule
